// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues word reads to instruction memory, presents
// one registered instruction at a time to decode, buffers a single word when
// decode back-pressures, and handles redirects (including ones that arrive
// while a read is still outstanding) and misaligned redirect targets.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pc_src,
  input  logic [31:0] pc_target,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  output logic [6:0]  op,
  output logic [2:0]  func3,
  output logic        func7b5,
  output logic        misalign
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_HOLD  = 3'd2,
    S_DRAIN = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic [31:0] redirect_pc;        // target remembered while draining a stale read
  logic [31:0] redirect_pc_next;
  logic [31:0] pend_instr;         // one-entry buffer, meaningful only in HOLD
  logic [31:0] pend_instr_next;
  logic [31:0] pend_pc;
  logic [31:0] pend_pc_next;
  logic [31:0] instr_next;
  logic [31:0] instr_pc_next;
  logic        instr_valid_next;
  logic        misalign_next;

  logic        consume;
  logic        slot_free;
  logic        redirect;
  logic        target_bad;

  assign consume    = instr_valid & ~stall;
  assign slot_free  = ~instr_valid | ~stall;
  assign redirect   = consume & pc_src;
  assign target_bad = (pc_target[1:0] != 2'b00);

  // Decode fields are straight slices of the held instruction.
  assign op      = instr[6:0];
  assign func3   = instr[14:12];
  assign func7b5 = instr[30];

  // Next-state and datapath decisions; every register holds unless a branch updates it.
  always_comb begin
    state_next       = state;
    pc_next          = pc;
    redirect_pc_next = redirect_pc;
    pend_instr_next  = pend_instr;
    pend_pc_next     = pend_pc;
    instr_next       = instr;
    instr_pc_next    = instr_pc;
    instr_valid_next = instr_valid;
    misalign_next    = misalign;
    imem_req         = 1'b0;
    imem_addr        = pc;

    case (state)
      S_IDLE: begin
        state_next = S_REQ;
      end

      S_REQ: begin
        imem_req = 1'b1;
        if (redirect) begin
          instr_valid_next = 1'b0;
          if (target_bad) begin
            // pc is left alone; an outstanding read must still be drained.
            misalign_next = 1'b1;
            state_next    = imem_ready ? S_HALT : S_DRAIN;
          end else if (imem_ready) begin
            // The word returning now belongs to the old path: drop it.
            pc_next    = pc_target;
            state_next = S_REQ;
          end else begin
            redirect_pc_next = pc_target;
            state_next       = S_DRAIN;
          end
        end else if (imem_ready) begin
          pc_next = pc + 32'd4;
          if (slot_free) begin
            instr_next       = imem_rdata;
            instr_pc_next    = pc;
            instr_valid_next = 1'b1;
            state_next       = S_REQ;
          end else begin
            pend_instr_next = imem_rdata;
            pend_pc_next    = pc;
            state_next      = S_HOLD;
          end
        end else begin
          // Nothing new arrived; a consumed instruction leaves the slot empty.
          instr_valid_next = consume ? 1'b0 : instr_valid;
          state_next       = S_REQ;
        end
      end

      S_HOLD: begin
        if (redirect) begin
          instr_valid_next = 1'b0;
          if (target_bad) begin
            misalign_next = 1'b1;
            state_next    = S_HALT;
          end else begin
            pc_next    = pc_target;
            state_next = S_REQ;
          end
        end else if (slot_free) begin
          instr_next       = pend_instr;
          instr_pc_next    = pend_pc;
          instr_valid_next = 1'b1;
          state_next       = S_REQ;
        end else begin
          state_next = S_HOLD;
        end
      end

      S_DRAIN: begin
        // Keep the old request on the bus until memory answers, then discard.
        imem_req = 1'b1;
        if (imem_ready) begin
          if (misalign) begin
            state_next = S_HALT;
          end else begin
            pc_next    = redirect_pc;
            state_next = S_REQ;
          end
        end else begin
          state_next = S_DRAIN;
        end
      end

      S_HALT: begin
        instr_valid_next = 1'b0;
        state_next       = S_HALT;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      pc          <= RESET_PC;
      redirect_pc <= 32'h0000_0000;
      pend_instr  <= 32'h0000_0000;
      pend_pc     <= 32'h0000_0000;
      instr       <= 32'h0000_0000;
      instr_pc    <= 32'h0000_0000;
      instr_valid <= 1'b0;
      misalign    <= 1'b0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      redirect_pc <= redirect_pc_next;
      pend_instr  <= pend_instr_next;
      pend_pc     <= pend_pc_next;
      instr       <= instr_next;
      instr_pc    <= instr_pc_next;
      instr_valid <= instr_valid_next;
      misalign    <= misalign_next;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: a directed cycle table, an async reset
// sequence, a randomized run checked against an instruction-stream model, a
// wrap-around check on a second instance, and a misaligned-redirect halt.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        pc_src;
  logic [31:0] pc_target;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic [6:0]  op;
  logic [2:0]  func3;
  logic        func7b5;
  logic        misalign;

  logic        d2_req;
  logic [31:0] d2_addr;
  logic [31:0] d2_rdata;
  logic [31:0] d2_instr;
  logic [31:0] d2_instr_pc;
  logic        d2_valid;
  logic [6:0]  d2_op;
  logic [2:0]  d2_func3;
  logic        d2_func7b5;
  logic        d2_misalign;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Memory contents: a distinct word for every address.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0F0F_1234;
  endfunction

  assign imem_rdata = memf(imem_addr);
  assign d2_rdata   = memf(d2_addr);

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .pc_src(pc_src), .pc_target(pc_target), .stall(stall),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .op(op), .func3(func3),
    .func7b5(func7b5), .misalign(misalign)
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .reset(reset), .pc_src(1'b0), .pc_target(32'h0000_0000), .stall(1'b0),
    .imem_req(d2_req), .imem_addr(d2_addr), .imem_ready(1'b1), .imem_rdata(d2_rdata),
    .instr(d2_instr), .instr_pc(d2_instr_pc), .instr_valid(d2_valid), .op(d2_op), .func3(d2_func3),
    .func7b5(d2_func7b5), .misalign(d2_misalign)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Instruction word and its decode fields must match memory at address a.
  task automatic chk_word(input string name, input logic [31:0] a);
    logic [31:0] w;
    w = memf(a);
    chk({name, "_instr"}, instr, w);
    chk({name, "_op"}, {25'd0, op}, {25'd0, w[6:0]});
    chk({name, "_func3"}, {29'd0, func3}, {29'd0, w[14:12]});
    chk({name, "_func7b5"}, {31'd0, func7b5}, {31'd0, w[30]});
  endtask

  task automatic chk_reset_vals(input string name);
    chk({name, "_req"}, {31'd0, imem_req}, 32'd0);
    chk({name, "_valid"}, {31'd0, instr_valid}, 32'd0);
    chk({name, "_instr"}, instr, 32'd0);
    chk({name, "_ipc"}, instr_pc, 32'd0);
    chk({name, "_mis"}, {31'd0, misalign}, 32'd0);
    chk({name, "_addr"}, imem_addr, 32'd0);
  endtask

  typedef struct {
    logic        stall;
    logic        ready;
    logic        src;
    logic [31:0] target;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_ipc;
    logic        e_mis;
  } vec_t;

  vec_t tbl [21];

  initial begin
    logic [31:0] exp_pc;
    logic [31:0] prev_addr;
    logic [31:0] t;
    logic        prev_hold;
    logic        prev_out;
    logic        found;
    int          consumed;

    // stall ready src target | req addr valid ipc mis  (outputs checked before inputs apply)
    tbl[0]  = '{1'b0, 1'b1, 1'b0, 32'h000, 1'b0, 32'h000, 1'b0, 32'h000, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 32'h000, 1'b1, 32'h000, 1'b0, 32'h000, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 32'h000, 1'b1, 32'h004, 1'b1, 32'h000, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 32'h000, 1'b0, 32'h008, 1'b1, 32'h000, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 32'h000, 1'b0, 32'h008, 1'b1, 32'h000, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 32'h000, 1'b1, 32'h008, 1'b1, 32'h004, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 32'h000, 1'b1, 32'h008, 1'b0, 32'h000, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 32'h100, 1'b1, 32'h00C, 1'b1, 32'h008, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 32'h000, 1'b1, 32'h00C, 1'b0, 32'h000, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 32'h000, 1'b1, 32'h00C, 1'b0, 32'h000, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 32'h000, 1'b1, 32'h100, 1'b0, 32'h000, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 32'h200, 1'b1, 32'h104, 1'b1, 32'h100, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 32'h000, 1'b1, 32'h200, 1'b0, 32'h000, 1'b0};
    tbl[13] = '{1'b1, 1'b1, 1'b0, 32'h000, 1'b1, 32'h204, 1'b1, 32'h200, 1'b0};
    tbl[14] = '{1'b0, 1'b1, 1'b1, 32'h300, 1'b0, 32'h208, 1'b1, 32'h200, 1'b0};
    tbl[15] = '{1'b0, 1'b0, 1'b1, 32'h400, 1'b1, 32'h300, 1'b0, 32'h000, 1'b0};
    tbl[16] = '{1'b0, 1'b1, 1'b0, 32'h000, 1'b1, 32'h300, 1'b0, 32'h000, 1'b0};
    tbl[17] = '{1'b0, 1'b0, 1'b1, 32'h102, 1'b1, 32'h304, 1'b1, 32'h300, 1'b0};
    tbl[18] = '{1'b0, 1'b1, 1'b0, 32'h000, 1'b1, 32'h304, 1'b0, 32'h000, 1'b1};
    tbl[19] = '{1'b0, 1'b1, 1'b1, 32'h500, 1'b0, 32'h304, 1'b0, 32'h000, 1'b1};
    tbl[20] = '{1'b0, 1'b1, 1'b0, 32'h000, 1'b0, 32'h000, 1'b0, 32'h000, 1'b1};

    reset = 1'b1; pc_src = 1'b0; pc_target = 32'd0; stall = 1'b0; imem_ready = 1'b0;
    #1;
    chk_reset_vals("por");
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Directed table: redirects in every state, hold buffer, drain, halt.
    for (int i = 0; i < 21; i++) begin
      chk($sformatf("row%0d_req", i), {31'd0, imem_req}, {31'd0, tbl[i].e_req});
      if (tbl[i].e_req) chk($sformatf("row%0d_addr", i), imem_addr, tbl[i].e_addr);
      chk($sformatf("row%0d_valid", i), {31'd0, instr_valid}, {31'd0, tbl[i].e_valid});
      if (tbl[i].e_valid) begin
        chk($sformatf("row%0d_ipc", i), instr_pc, tbl[i].e_ipc);
        chk_word($sformatf("row%0d", i), tbl[i].e_ipc);
      end
      chk($sformatf("row%0d_mis", i), {31'd0, misalign}, {31'd0, tbl[i].e_mis});
      if (i >= 2 && i <= 4) begin
        chk($sformatf("wrap%0d_valid", i), {31'd0, d2_valid}, 32'd1);
        chk($sformatf("wrap%0d_ipc", i), d2_instr_pc, 32'hFFFF_FFF8 + 32'(4 * (i - 2)));
      end
      stall = tbl[i].stall; imem_ready = tbl[i].ready;
      pc_src = tbl[i].src; pc_target = tbl[i].target;
      @(negedge clk);
    end

    // Reset from HALT, then reset again in the middle of an outstanding read.
    pc_src = 1'b0; stall = 1'b0; imem_ready = 1'b0;
    #2 reset = 1'b1;
    #1 chk_reset_vals("rst_halt");
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_req", {31'd0, imem_req}, 32'd1);
    #2 reset = 1'b1;
    #1 chk_reset_vals("rst_async");
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      imem_ready = k[0];
      chk_reset_vals($sformatf("rst_hold%0d", k));
    end
    @(negedge clk);
    reset = 1'b0; imem_ready = 1'b1;
    chk("rel_idle_req", {31'd0, imem_req}, 32'd0);
    @(negedge clk);
    chk("rel_req", {31'd0, imem_req}, 32'd1);
    chk("rel_addr", imem_addr, 32'd0);
    chk("rel_valid0", {31'd0, instr_valid}, 32'd0);
    @(negedge clk);
    chk("rel_valid1", {31'd0, instr_valid}, 32'd1);
    chk("rel_ipc", instr_pc, 32'd0);
    chk_word("rel", 32'd0);
    @(negedge clk);
    chk("rel_ipc4", instr_pc, 32'd4);

    // Randomized run against the instruction-stream model.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_pc = 32'd0; prev_hold = 1'b0; prev_out = 1'b0; prev_addr = 32'd0; consumed = 0;
    for (int c = 0; c < 3000; c++) begin
      if (instr_valid) begin
        chk("rnd_ipc", instr_pc, exp_pc);
        chk_word("rnd", exp_pc);
      end
      if (prev_hold) chk("rnd_held", {31'd0, instr_valid}, 32'd1);
      if (prev_out) begin
        chk("rnd_req_stable", {31'd0, imem_req}, 32'd1);
        chk("rnd_addr_stable", imem_addr, prev_addr);
      end
      if (imem_req) chk("rnd_align", {30'd0, imem_addr[1:0]}, 32'd0);
      chk("rnd_mis", {31'd0, misalign}, 32'd0);

      stall      = ($urandom_range(0, 99) < 30);
      imem_ready = ($urandom_range(0, 99) < 60);
      pc_src     = ($urandom_range(0, 99) < 15);
      t = 32'($urandom_range(0, 1023)) << 2;
      if ($urandom_range(0, 99) < 5) t = 32'hFFFF_FFF8;
      pc_target = t;

      if (instr_valid && !stall) begin
        consumed++;
        exp_pc = pc_src ? t : exp_pc + 32'd4;
      end
      prev_hold = instr_valid && stall;
      prev_out  = imem_req && !imem_ready;
      prev_addr = imem_addr;
      @(negedge clk);
    end
    checks++;
    if (consumed < 300) begin
      failures++;
      $display("FAIL rnd_progress actual=%0d required>=300", consumed);
    end

    // Misaligned redirect: halt until reset.
    found = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (instr_valid) begin
        found = 1'b1;
        break;
      end
      stall = 1'b0; imem_ready = 1'b1; pc_src = 1'b0;
      @(negedge clk);
    end
    chk("mis_found_valid", {31'd0, found}, 32'd1);
    stall = 1'b0; imem_ready = 1'b1; pc_src = 1'b1; pc_target = 32'h0000_0042;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("halt%0d_mis", k), {31'd0, misalign}, 32'd1);
      chk($sformatf("halt%0d_req", k), {31'd0, imem_req}, 32'd0);
      chk($sformatf("halt%0d_valid", k), {31'd0, instr_valid}, 32'd0);
      pc_src = k[0]; stall = k[1]; pc_target = 32'h0000_0100;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 pc_src  input  1  redirect request from controller for the instruction currently on instr.
REQ-005 pc_target  input  32  redirect address (branch/jump target).
REQ-006 stall  input  1  downstream not accepting; instr held while high.
REQ-007 imem_req  output  1  instruction memory read request.
REQ-008 imem_addr  output  32  read address, word aligned.
REQ-009 imem_ready  input  1  read data valid on imem_rdata this cycle.
REQ-010 imem_rdata  input  32  instruction word from memory.
REQ-011 instr  output  32  registered instruction to decode.
REQ-012 instr_pc  output  32  address of instr.
REQ-013 instr_valid  output  1  instr/instr_pc valid.
REQ-014 op  output  7  instr[6:0], combinational.
REQ-015 func3  output  3  instr[14:12], combinational.
REQ-016 func7b5  output  1  instr[30], combinational.
REQ-017 misalign  output  1  sticky flag, redirect to non-word-aligned target.

Function
REQ-018 FSM states SHALL be IDLE, REQ, HOLD, DRAIN, HALT.
REQ-019 Consume SHALL be defined as instr_valid & ~stall in a cycle; slot_free = ~instr_valid | ~stall.
REQ-020 IDLE: imem_req=0; next state REQ unconditionally.
REQ-021 REQ: imem_req=1, imem_addr=pc; req and addr SHALL stay stable until imem_ready.
REQ-022 REQ, imem_ready=1, slot_free, no redirect: instr<=imem_rdata, instr_pc<=pc, instr_valid<=1, pc<=pc+4, stay REQ.
REQ-023 REQ, imem_ready=1, ~slot_free: imem_rdata and pc SHALL be captured in a one-entry pending buffer, pc<=pc+4, go HOLD.
REQ-024 HOLD: imem_req=0; on slot_free, pending SHALL move to instr/instr_pc with instr_valid=1, go REQ.
REQ-025 Consume without a new word loaded SHALL clear instr_valid next cycle.
REQ-026 pc_src SHALL be sampled only on a consume cycle; otherwise ignored.
REQ-027 Redirect (pc_src on consume): pc<=pc_target, instr_valid<=0, pending buffer discarded.
REQ-028 Redirect in REQ with imem_ready=1 same cycle: returned word discarded, next state REQ at pc_target.
REQ-029 Redirect in REQ with imem_ready=0: next state DRAIN; imem_req held with old address until imem_ready, data discarded, then REQ at pc_target.
REQ-030 Redirect in HOLD: pending discarded, next state REQ at pc_target.
REQ-031 Redirect with pc_target[1:0]!=0: misalign<=1, instr_valid<=0, state HALT; pc unchanged.
REQ-032 HALT: imem_req=0, instr_valid=0, all inputs ignored until reset; if entered from REQ with request outstanding, state SHALL pass through DRAIN first then HALT.
REQ-033 pc arithmetic SHALL be 32-bit modulo: 32'hFFFF_FFFC+4 = 32'h0000_0000.
REQ-034 imem_ready SHALL be ignored whenever imem_req=0.
REQ-035 Zero-wait memory, no stall: one instruction per cycle, instr_valid one cycle after imem_ready.

Reset
REQ-036 reset high SHALL immediately force state=IDLE, pc=RESET_PC, instr=0, instr_pc=0, instr_valid=0, imem_req=0, misalign=0, pending cleared, regardless of clk.
REQ-037 Reset mid-transaction SHALL abandon the outstanding request; no returned data is used.
REQ-038 First rising edge after reset release SHALL move IDLE->REQ with imem_addr=RESET_PC.

Verification
REQ-039 Reset release, imem_ready tied 1, rdata=addr-derived -> instr_valid=1 from edge 2, instr_pc 0,4,8,... one per cycle.
REQ-040 stall=1 while word at 0x4 returns -> word held in HOLD, imem_req=0; stall=0 -> instr_pc=0x4 presented, then fetch 0x8.
REQ-041 pc_src=1, pc_target=0x100 on consume with imem_ready=0 -> DRAIN, stale word dropped, next imem_addr=0x100, no instr_valid between.
REQ-042 pc_src=1, pc_target=0x102 -> misalign=1, imem_req=0, instr_valid=0 until reset.
REQ-043 RESET_PC=32'hFFFF_FFF8, zero-wait -> instr_pc FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-044 reset asserted mid-REQ, imem_ready pulses during reset -> outputs stay reset values, restart at RESET_PC.
